sound_latch_sequencer: RTL and testbench
========================================

# sound_latch_sequencer

Controller between the CPU sound-port write and the shell/explosion noise generator. It latches CPU writes and commits them only on 12 kHz sound ticks. It runs one small state machine per noise channel so that every trigger produces an enable pulse of guaranteed minimum length followed by a guaranteed low gap. This keeps the noise channels' decay envelopes retriggering cleanly regardless of how fast or briefly software toggles the bits.

## Interface
Parameters:
- HOLD_TICKS, 64, minimum number of 12 kHz ticks a channel enable stays high once fired (≥1)
- GAP_TICKS, 2, number of 12 kHz ticks a channel enable is forced low after release (≥1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- clk_12KHz_en  in  1  one-cycle sound tick enable
- cpu_we  in  1  one-cycle write strobe to the sound register
- cpu_data  in  8  write data
- sound_enable  out  1  master sound enable (committed bit 5)
- shell_en  out  1  shell noise channel enable
- shell_ls  out  1  shell loud/soft, captured at fire
- explo_en  out  1  explosion noise channel enable
- explo_ls  out  1  explosion loud/soft, captured at fire
- shell_busy  out  1  shell FSM not IDLE
- explo_busy  out  1  explosion FSM not IDLE

## Operation
- Bit map: D0 explo_ls, D1 shell_ls, D2 shell request, D3 explo request, D5 master enable; other bits ignored.
- Shadow register: cpu_we loads cpu_data; last write before a tick wins.
- Commit: on clk_12KHz_en, shadow is copied to committed register. If cpu_we and clk_12KHz_en coincide, cpu_data is committed directly (bypass).
- Request edge: rise = committed request bit 1 while previous committed value was 0. Evaluated only at commit.
- Per-channel FSM, all transitions on ticks only:
  - IDLE: en=0. A rise moves it to HOLD: load counter with HOLD_TICKS and capture the ls bit into the ls output.
  - HOLD: en=1. Decrement each tick. At counter reaching 0: if request bit still 1, go ON; otherwise go GAP (counter=GAP_TICKS).
  - ON: en=1. When request bit reads 0 at a commit, go GAP (counter=GAP_TICKS).
  - GAP: en=0. Decrement each tick. At 0 go IDLE, or go straight to HOLD if a rise was latched during GAP (pending flag, cleared on fire).
- Rises during HOLD/ON are ignored (no retrigger without a gap).
- ls outputs change only on fire; they hold their value through GAP/IDLE.
- Master off: committed bit5=0 forces both FSMs to IDLE and clears pending flags at that tick. No new fires occur while bit5=0. Request bits are still tracked, so a request already high when bit5 returns to 1 does not fire.
- Counter width: $clog2(max(HOLD_TICKS,GAP_TICKS)+1).

## Timing
- Reset: all outputs 0, shadow/committed registers 0, FSMs IDLE, pending 0.
- All outputs registered; they change in the cycle after the tick that causes the transition.
- Latency from a write to en rise: up to one tick period plus 1 clk.
- Enable pulse length: exactly HOLD_TICKS ticks if the request drops before hold ends. Otherwise HOLD_TICKS plus the ON duration.
- Minimum low time between pulses: GAP_TICKS ticks.
- Reset mid-operation: immediate asynchronous return to reset state.

## Test plan
- Reset, then write 0x24 (master+shell), tick → shell_en=1 one clk after the tick, shell_ls=0, shell_busy=1. Write 0x20, then after 64 ticks → shell_en=0. After 2 more ticks → shell_busy=0.
- Write 0x2B (master, explo req, both ls), tick; then write 0x20 next tick → explo_en=1 for exactly 64 ticks, explo_ls=1, and explo_ls stays 1 after the release.
- Write 0x28 and hold it for 100 ticks, then write 0x20 → explo_en high 100 ticks (ON state), then low for 2 ticks, then IDLE.
- Shell fires and is released into GAP; write 0x24 during the first GAP tick → shell_en goes low for exactly 2 ticks, then re-fires without another write.
- Write 0x2C, then 0x0C before the next tick → nothing fires, all en=0. Then write 0x2C → no fire (no rise); write 0x20, then 0x2C → both channels fire.
- cpu_we coincident with clk_12KHz_en carrying 0x24 → shell fires on that tick. Assert rst_n=0 mid-HOLD → all outputs 0 immediately.

Source files
------------

// File: rtl/sound_latch_sequencer.sv
// Latches CPU sound-port writes, commits them on 12 kHz ticks, sequences shell/explosion enable pulses.
// Latency: committed state and enables update the clk after a tick; write-to-enable is up to one tick period + 1 clk.
// Backpressure: none; writes are always accepted and the last write before a tick wins.
module sound_latch_sequencer #(
    parameter int HOLD_TICKS = 64,
    parameter int GAP_TICKS  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_12KHz_en,
    input  logic       cpu_we,
    input  logic [7:0] cpu_data,
    output logic       sound_enable,
    output logic       shell_en,
    output logic       shell_ls,
    output logic       explo_en,
    output logic       explo_ls,
    output logic       shell_busy,
    output logic       explo_busy
);

    localparam int MAX_TICKS = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_TICKS);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_TICKS);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [7:0]    shadow;
    logic [7:0]    committed;
    logic [7:0]    next_commit;
    logic [1:0]    req_new;
    logic [1:0]    req_old;
    logic [1:0]    ls_new;
    logic [1:0]    rise;
    logic          master_new;

    // Channel index 0 is shell, 1 is explosion.
    logic [1:0]    state [2];
    logic [CW-1:0] cnt   [2];
    logic [1:0]    pend;
    logic [1:0]    ls_q;

    // A write coinciding with a tick bypasses the shadow and commits directly.
    assign next_commit = cpu_we ? cpu_data : shadow;
    assign req_new     = {next_commit[3], next_commit[2]};
    assign req_old     = {committed[3], committed[2]};
    assign ls_new      = {next_commit[0], next_commit[1]};
    assign rise        = req_new & ~req_old;
    assign master_new  = next_commit[5];

    // Shadow captures every write; committed copy only moves on a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            committed <= '0;
        end else begin
            if (cpu_we) begin
                shadow <= cpu_data;
            end
            if (clk_12KHz_en) begin
                committed <= next_commit;
            end
        end
    end

    // Per-channel pulse sequencer: fire -> minimum hold -> optional on -> forced gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                state[c] <= S_IDLE;
                cnt[c]   <= '0;
            end
            pend <= '0;
            ls_q <= '0;
        end else if (clk_12KHz_en) begin
            for (int c = 0; c < 2; c++) begin
                if (!master_new) begin
                    // Master off kills any pulse and any queued retrigger.
                    state[c] <= S_IDLE;
                    cnt[c]   <= '0;
                    pend[c]  <= 1'b0;
                end else begin
                    case (state[c])
                        S_IDLE: begin
                            if (rise[c]) begin
                                state[c] <= S_HOLD;
                                cnt[c]   <= HOLD_LOAD;
                                ls_q[c]  <= ls_new[c];
                                pend[c]  <= 1'b0;
                            end
                        end
                        S_HOLD: begin
                            if (cnt[c] <= CNT_ONE) begin
                                if (req_new[c]) begin
                                    state[c] <= S_ON;
                                    cnt[c]   <= '0;
                                end else begin
                                    state[c] <= S_GAP;
                                    cnt[c]   <= GAP_LOAD;
                                end
                            end else begin
                                cnt[c] <= cnt[c] - CNT_ONE;
                            end
                        end
                        S_ON: begin
                            if (!req_new[c]) begin
                                state[c] <= S_GAP;
                                cnt[c]   <= GAP_LOAD;
                            end
                        end
                        default: begin
                            // A rise on the final gap tick counts as pending too.
                            if (cnt[c] <= CNT_ONE) begin
                                if (pend[c] || rise[c]) begin
                                    state[c] <= S_HOLD;
                                    cnt[c]   <= HOLD_LOAD;
                                    ls_q[c]  <= ls_new[c];
                                    pend[c]  <= 1'b0;
                                end else begin
                                    state[c] <= S_IDLE;
                                    cnt[c]   <= '0;
                                end
                            end else begin
                                cnt[c] <= cnt[c] - CNT_ONE;
                                if (rise[c]) begin
                                    pend[c] <= 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign sound_enable = committed[5];
    assign shell_en     = (state[0] == S_HOLD) || (state[0] == S_ON);
    assign explo_en     = (state[1] == S_HOLD) || (state[1] == S_ON);
    assign shell_busy   = (state[0] != S_IDLE);
    assign explo_busy   = (state[1] != S_IDLE);
    assign shell_ls     = ls_q[0];
    assign explo_ls     = ls_q[1];

endmodule

// File: tb/tb_sound_latch_sequencer.sv
// Bench for sound_latch_sequencer: vector table, directed tick sequences and randomized writes vs. a behavioural model.
// Latency: model is advanced at each rising edge and outputs are compared 1 time unit later.
// Backpressure: not applicable; inputs are driven freely every cycle.
module tb_sound_latch_sequencer;

    localparam int HOLD = 64;
    localparam int GAP  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_12KHz_en = 1'b0;
    logic       cpu_we = 1'b0;
    logic [7:0] cpu_data = '0;
    logic       sound_enable, shell_en, shell_ls, explo_en, explo_ls, shell_busy, explo_busy;

    int checks = 0;
    int failures = 0;

    sound_latch_sequencer #(.HOLD_TICKS(HOLD), .GAP_TICKS(GAP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_12KHz_en (clk_12KHz_en),
        .cpu_we       (cpu_we),
        .cpu_data     (cpu_data),
        .sound_enable (sound_enable),
        .shell_en     (shell_en),
        .shell_ls     (shell_ls),
        .explo_en     (explo_en),
        .explo_ls     (explo_ls),
        .shell_busy   (shell_busy),
        .explo_busy   (explo_busy)
    );

    always #5 clk = ~clk;

    // Behavioural model, channel 0 = shell (req D2, ls D1), channel 1 = explosion (req D3, ls D0).
    logic [7:0] m_shadow, m_commit;
    bit         m_en [2];
    bit         m_busy [2];
    bit         m_ls [2];
    bit         m_pend [2];
    int         m_left [2];   // ticks remaining of minimum hold (while enabled) or of the gap

    task automatic model_reset();
        m_shadow = '0;
        m_commit = '0;
        for (int c = 0; c < 2; c++) begin
            m_en[c] = 0; m_busy[c] = 0; m_ls[c] = 0; m_pend[c] = 0; m_left[c] = 0;
        end
    endtask

    task automatic model_fire(input int c, input bit lsb);
        m_en[c] = 1; m_busy[c] = 1; m_ls[c] = lsb; m_pend[c] = 0; m_left[c] = HOLD;
    endtask

    task automatic model_tick(input logic [7:0] nv);
        for (int c = 0; c < 2; c++) begin
            bit req, old, rise;
            req  = nv[2 + c];
            old  = m_commit[2 + c];
            rise = req && !old;
            if (!nv[5]) begin
                m_en[c] = 0; m_busy[c] = 0; m_pend[c] = 0; m_left[c] = 0;
            end else if (m_en[c]) begin
                if (m_left[c] > 0) m_left[c]--;
                if (m_left[c] == 0 && !req) begin
                    m_en[c] = 0;
                    m_left[c] = GAP;
                end
            end else if (m_busy[c]) begin
                if (rise) m_pend[c] = 1;
                m_left[c]--;
                if (m_left[c] == 0) begin
                    if (m_pend[c]) model_fire(c, nv[1 - c]);
                    else m_busy[c] = 0;
                end
            end else if (rise) begin
                model_fire(c, nv[1 - c]);
            end
        end
        m_commit = nv;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("sound_enable", {7'd0, sound_enable}, {7'd0, m_commit[5]});
        chk("shell_en",     {7'd0, shell_en},     {7'd0, m_en[0]});
        chk("shell_ls",     {7'd0, shell_ls},     {7'd0, m_ls[0]});
        chk("shell_busy",   {7'd0, shell_busy},   {7'd0, m_busy[0]});
        chk("explo_en",     {7'd0, explo_en},     {7'd0, m_en[1]});
        chk("explo_ls",     {7'd0, explo_ls},     {7'd0, m_ls[1]});
        chk("explo_busy",   {7'd0, explo_busy},   {7'd0, m_busy[1]});
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic step(input bit we, input logic [7:0] d, input bit tk);
        cpu_we = we; cpu_data = d; clk_12KHz_en = tk;
        @(posedge clk);
        if (tk) model_tick(we ? d : m_shadow);
        if (we) m_shadow = d;
        #1;
        cpu_we = 0; clk_12KHz_en = 0;
        check_model();
    endtask

    task automatic wr(input logic [7:0] d);
        step(1, d, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 8'h00, 0);
            step(0, 8'h00, 1);
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("reset_async_outputs",
            {1'b0, sound_enable, shell_en, shell_ls, shell_busy, explo_en, explo_ls, explo_busy}, 8'h00);
        check_model();
        @(posedge clk);
        #1;
        rst_n = 1;
        step(0, 8'h00, 0);
    endtask

    typedef struct {
        bit         we;
        logic [7:0] d;
        bit         tk;
        logic [6:0] exp;   // {sound_enable, shell_en, shell_ls, shell_busy, explo_en, explo_ls, explo_busy}
    } vec_t;

    vec_t vt [7];

    initial begin
        vt[0] = '{we: 0, d: 8'h00, tk: 0, exp: 7'b0000000};
        vt[1] = '{we: 1, d: 8'h24, tk: 0, exp: 7'b0000000};
        vt[2] = '{we: 0, d: 8'h00, tk: 1, exp: 7'b1101000};
        vt[3] = '{we: 1, d: 8'h2B, tk: 1, exp: 7'b1101111};
        vt[4] = '{we: 1, d: 8'h0B, tk: 0, exp: 7'b1101111};
        vt[5] = '{we: 0, d: 8'h00, tk: 1, exp: 7'b0000010};
        vt[6] = '{we: 1, d: 8'h2F, tk: 1, exp: 7'b1111010};

        model_reset();
        do_reset();

        // Vector table: commit, bypass, master-off and no-rise-on-master-return.
        for (int i = 0; i < 7; i++) begin
            step(vt[i].we, vt[i].d, vt[i].tk);
            chk($sformatf("vec%0d", i),
                {1'b0, sound_enable, shell_en, shell_ls, shell_busy, explo_en, explo_ls, explo_busy},
                {1'b0, vt[i].exp});
        end

        // Shell minimum hold, gap, and retrigger pending from the first gap tick.
        do_reset();
        wr(8'h24);
        ticks(1);
        chk("shell_fire", {7'd0, shell_en}, 8'd1);
        wr(8'h20);
        ticks(HOLD - 1);
        chk("shell_hold_end_minus1", {7'd0, shell_en}, 8'd1);
        ticks(1);
        chk("shell_released", {6'd0, shell_en, shell_busy}, 8'd1);
        wr(8'h24);
        ticks(1);
        chk("shell_gap_pending", {6'd0, shell_en, shell_busy}, 8'd1);
        ticks(1);
        chk("shell_refire", {6'd0, shell_en, shell_busy}, 8'd3);

        // Explosion held 100 ticks enters ON, then gap, then idle.
        do_reset();
        wr(8'h28);
        ticks(1);
        ticks(99);
        chk("explo_on_99", {6'd0, explo_en, explo_ls}, 8'd2);
        wr(8'h20);
        ticks(1);
        chk("explo_off_100", {6'd0, explo_en, explo_busy}, 8'd1);
        ticks(2);
        chk("explo_idle", {7'd0, explo_busy}, 8'd0);

        // Explosion with ls set, released next tick: exactly HOLD ticks, ls held afterwards.
        do_reset();
        wr(8'h2B);
        ticks(1);
        wr(8'h20);
        ticks(HOLD - 1);
        chk("explo_ls_hold", {6'd0, explo_en, explo_ls}, 8'd3);
        ticks(1);
        chk("explo_ls_after", {6'd0, explo_en, explo_ls}, 8'd1);
        ticks(3);

        // Master-off latching: no fire, no rise on return, fire after a clean low.
        wr(8'h2C);
        wr(8'h0C);
        ticks(1);
        chk("masteroff_nofire", {6'd0, shell_en, explo_en}, 8'd0);
        wr(8'h2C);
        ticks(1);
        chk("return_norise", {6'd0, shell_en, explo_en}, 8'd0);
        wr(8'h20);
        ticks(1);
        wr(8'h2C);
        ticks(1);
        chk("both_fire", {6'd0, shell_en, explo_en}, 8'd3);
        ticks(5);
        // Asynchronous reset in the middle of HOLD.
        do_reset();

        // Randomized writes and ticks against the model, with occasional reset.
        for (int i = 0; i < 6000; i++) begin
            logic [7:0] d;
            bit we, tk;
            d  = 8'($urandom);
            if ($urandom_range(0, 15) != 0) d[5] = 1'b1;
            we = ($urandom_range(0, 19) == 0);
            tk = ($urandom_range(0, 1) == 0);
            step(we, d, tk);
            if (i == 3000) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
